// File: rtl/tpu_sched_pkg.sv
// Shared types and defaults for the TPU job scheduler: FSM states, descriptor
// and completion record layouts, and the default watchdog/reset-pulse settings.
package tpu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RECOVER,
    S_REPORT
  } state_t;

  localparam int SET_W          = 2;
  localparam int DEF_ID_W       = 4;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_TIMEOUT    = 4095;
  localparam int DEF_RST_CYCLES = 4;

  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [SET_W-1:0]    set;
  } desc_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_CYC_W-1:0] cycles;
    logic                 timeout;
  } cmp_t;

  // Packed descriptor width for a given tag width ({id, set}, id in the MSBs).
  function automatic int desc_width(input int id_w);
    return id_w + SET_W;
  endfunction

endpackage

// File: rtl/tpu_job_fifo.sv
// Synchronous job FIFO with registered occupancy; full/empty decode from the
// occupancy register so a same-cycle pop never frees space for a push.
module tpu_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Job sequencer in front of tpu_top: queue descriptors, start/time each job,
// recover from hangs via tpu_rst_req, and return one completion per job.
//   state   | meaning
//   IDLE    | wait for a queued job, pop it
//   START   | one-cycle tpu_start, counter = 0
//   RUN     | count cycles until tpu_done or watchdog
//   RECOVER | hold tpu_rst_req for RST_CYCLES cycles
//   REPORT  | offer completion record until cmp_ready
module tpu_job_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int ID_W       = DEF_ID_W,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  localparam int LVL_W     = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [ID_W-1:0]  job_id,
  input  logic [1:0]       job_set,
  output logic             tpu_start,
  output logic [1:0]       tpu_job_set,
  input  logic             tpu_done,
  output logic             tpu_rst_req,
  output logic             cmp_valid,
  input  logic             cmp_ready,
  output logic [ID_W-1:0]  cmp_id,
  output logic [CYC_W-1:0] cmp_cycles,
  output logic             cmp_timeout,
  output logic             busy,
  output logic [LVL_W-1:0] q_level
);

  localparam int DW  = desc_width(ID_W);
  localparam int RCW = $clog2(RST_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [1:0]       set_d;
  logic             start_d, rst_req_d, valid_d, to_d;
  logic [ID_W-1:0]  cmp_id_d;
  logic [CYC_W-1:0] cycles_d;
  logic [DW-1:0]    head;
  logic             full, empty, pop;

  tpu_job_fifo #(.DEPTH(QDEPTH), .W(DW)) u_fifo (
    .clk   (clk),
    .srst  (srst),
    .push  (job_valid),
    .pop   (pop),
    .wdata ({job_id, job_set}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (q_level)
  );

  // job_ready must read 0 while reset is held, 1 right after release.
  assign job_ready = !full && !srst;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    cur_id_d  = cur_id_q;
    set_d     = tpu_job_set;
    start_d   = 1'b0;
    rst_req_d = tpu_rst_req;
    valid_d   = cmp_valid;
    cmp_id_d  = cmp_id;
    cycles_d  = cmp_cycles;
    to_d      = cmp_timeout;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          cur_id_d = head[DW-1 -: ID_W];
          set_d    = head[SET_W-1:0];
          start_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d   = cnt_inc;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done is checked first so it wins a tie with the watchdog.
        if (tpu_done) begin
          valid_d  = 1'b1;
          cmp_id_d = cur_id_q;
          cycles_d = cnt_q;
          to_d     = 1'b0;
          state_d  = S_REPORT;
        end else if (cnt_q >= CYC_W'(TIMEOUT)) begin
          cmp_id_d  = cur_id_q;
          cycles_d  = CYC_W'(TIMEOUT);
          to_d      = 1'b1;
          rst_req_d = 1'b1;
          rcnt_d    = RCW'(RST_CYCLES - 1);
          state_d   = S_RECOVER;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RECOVER: begin
        if (rcnt_q == '0) begin
          rst_req_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_REPORT;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end
      S_REPORT: begin
        if (cmp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      cur_id_q    <= '0;
      tpu_start   <= 1'b0;
      tpu_job_set <= '0;
      tpu_rst_req <= 1'b0;
      cmp_valid   <= 1'b0;
      cmp_id      <= '0;
      cmp_cycles  <= '0;
      cmp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      cur_id_q    <= cur_id_d;
      tpu_start   <= start_d;
      tpu_job_set <= set_d;
      tpu_rst_req <= rst_req_d;
      cmp_valid   <= valid_d;
      cmp_id      <= cmp_id_d;
      cmp_cycles  <= cycles_d;
      cmp_timeout <= to_d;
    end
  end

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Self-checking bench for tpu_job_scheduler: directed scenarios plus a
// randomized run checked against a queue-based model of the job contract.
module tb_tpu_job_scheduler;

  localparam int QDEPTH     = 4;
  localparam int ID_W       = 4;
  localparam int CYC_W      = 16;
  localparam int TIMEOUT    = 20;
  localparam int RST_CYCLES = 4;

  logic             clk = 1'b0;
  logic             srst = 1'b0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [ID_W-1:0]  job_id = '0;
  logic [1:0]       job_set = '0;
  logic             tpu_start;
  logic [1:0]       tpu_job_set;
  logic             tpu_done = 1'b0;
  logic             tpu_rst_req;
  logic             cmp_valid;
  logic             cmp_ready = 1'b0;
  logic [ID_W-1:0]  cmp_id;
  logic [CYC_W-1:0] cmp_cycles;
  logic             cmp_timeout;
  logic             busy;
  logic [2:0]       q_level;

  int vectors = 0;
  int errors  = 0;

  tpu_job_scheduler #(
    .QDEPTH(QDEPTH), .ID_W(ID_W), .CYC_W(CYC_W),
    .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .srst(srst), .job_valid(job_valid), .job_ready(job_ready),
    .job_id(job_id), .job_set(job_set), .tpu_start(tpu_start),
    .tpu_job_set(tpu_job_set), .tpu_done(tpu_done), .tpu_rst_req(tpu_rst_req),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
    .cmp_cycles(cmp_cycles), .cmp_timeout(cmp_timeout), .busy(busy),
    .q_level(q_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int all_out;
    srst = 1'b0;
    #2 srst = 1'b1;
    #2;
    all_out = int'({tpu_start, tpu_rst_req, cmp_valid, cmp_id, cmp_cycles,
                    cmp_timeout, tpu_job_set, busy, q_level, job_ready});
    vectors++;
    if (all_out !== 0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", all_out); end
    tick(); tick();
    vectors++;
    if (job_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held: got %0b expected 0", job_ready); end
    #2 srst = 1'b0;
    #1;
    vectors++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || int'(q_level) != 0) begin
      errors++; $display("FAIL reset_release: ready %0b busy %0b level %0d expected 1 0 0", job_ready, busy, q_level);
    end
  endtask

  // Leaves the record pending (cmp_ready=0) for the back-to-back scenario.
  task automatic test_single();
    cmp_ready = 1'b0;
    tick();
    job_valid = 1'b1; job_id = 4'd3; job_set = 2'd1;
    tick();
    job_valid = 1'b0;
    vectors++;
    if (tpu_start !== 1'b0 || int'(q_level) != 1) begin
      errors++; $display("FAIL single_after_push: start %0b level %0d expected 0 1", tpu_start, q_level);
    end
    tick();
    vectors++;
    if (tpu_start !== 1'b1 || tpu_job_set !== 2'd1) begin
      errors++; $display("FAIL single_start: start %0b set %0d expected 1 1", tpu_start, tpu_job_set);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        vectors++;
        if (tpu_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %0b expected 0", tpu_start); end
      end
      tpu_done = (k == 10);
    end
    tick();
    tpu_done = 1'b0;
    vectors++;
    if (cmp_valid !== 1'b1 || int'(cmp_id) != 3 || int'(cmp_cycles) != 10 || cmp_timeout !== 1'b0 || tpu_job_set !== 2'd1) begin
      errors++; $display("FAIL single_record: valid %0b id %0d cyc %0d to %0b set %0d expected 1 3 10 0 1",
                         cmp_valid, cmp_id, cmp_cycles, cmp_timeout, tpu_job_set);
    end
  endtask

  task automatic test_back_to_back();
    int exp_id[5]  = '{3, 1, 2, 3, 4};
    int exp_cyc[5] = '{10, 3, 4, 5, 6};
    int starts = 0, got = 0, tcyc = 0, dly = 0;
    bit armed = 0;
    for (int i = 1; i <= 4; i++) begin
      job_valid = 1'b1; job_id = ID_W'(i); job_set = 2'(i % 4);
      tick();
    end
    job_valid = 1'b0;
    vectors++;
    if (int'(q_level) != 4 || job_ready !== 1'b0 || cmp_valid !== 1'b1 || int'(cmp_id) != 3) begin
      errors++; $display("FAIL b2b_full: level %0d ready %0b valid %0b id %0d expected 4 0 1 3", q_level, job_ready, cmp_valid, cmp_id);
    end
    cmp_ready = 1'b1;
    for (int c = 0; c < 200 && got < 5; c++) begin
      if (tpu_start) begin
        starts++;
        armed = 1; tcyc = 0; dly = 2 + starts;
        vectors++;
        if (int'(tpu_job_set) != starts % 4) begin
          errors++; $display("FAIL b2b_set: start %0d got %0d expected %0d", starts, tpu_job_set, starts % 4);
        end
      end else if (armed) tcyc++;
      tpu_done = armed && (tcyc == dly);
      if (cmp_valid) begin
        vectors++;
        if (int'(cmp_id) != exp_id[got] || int'(cmp_cycles) != exp_cyc[got] || cmp_timeout !== 1'b0) begin
          errors++; $display("FAIL b2b_record %0d: id %0d cyc %0d to %0b expected %0d %0d 0",
                             got, cmp_id, cmp_cycles, cmp_timeout, exp_id[got], exp_cyc[got]);
        end
        got++;
      end
      if (got < 5) tick();
    end
    tick();
    tpu_done = 1'b0;
    vectors++;
    if (starts != 4 || got != 5) begin
      errors++; $display("FAIL b2b_counts: starts %0d records %0d expected 4 5", starts, got);
    end
  endtask

  task automatic test_timeout();
    int first_rq = -1, rq_n = 0, at = -1;
    cmp_ready = 1'b1;
    job_valid = 1'b1; job_id = 4'd5; job_set = 2'd2;
    tick();
    job_valid = 1'b0;
    tick();
    vectors++;
    if (tpu_start !== 1'b1) begin errors++; $display("FAIL timeout_start: got %0b expected 1", tpu_start); end
    for (int c = 1; c <= 40 && at < 0; c++) begin
      tick();
      if (tpu_rst_req) begin
        if (first_rq < 0) first_rq = c;
        rq_n++;
      end
      if (cmp_valid) at = c;
    end
    vectors++;
    if (first_rq != TIMEOUT + 1 || rq_n != RST_CYCLES) begin
      errors++; $display("FAIL timeout_rst_req: first %0d len %0d expected %0d %0d", first_rq, rq_n, TIMEOUT + 1, RST_CYCLES);
    end
    vectors++;
    if (at != TIMEOUT + 1 + RST_CYCLES || int'(cmp_id) != 5 || int'(cmp_cycles) != TIMEOUT || cmp_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_record: at %0d id %0d cyc %0d to %0b expected %0d 5 %0d 1",
                         at, cmp_id, cmp_cycles, cmp_timeout, TIMEOUT + 1 + RST_CYCLES, TIMEOUT);
    end
    tick();
  endtask

  task automatic test_race();
    int at = -1, rq_n = 0;
    cmp_ready = 1'b1;
    job_valid = 1'b1; job_id = 4'd9; job_set = 2'd3;
    tick();
    job_valid = 1'b0;
    tick();
    for (int c = 1; c <= 40 && at < 0; c++) begin
      tick();
      if (tpu_rst_req) rq_n++;
      if (cmp_valid) at = c;
      tpu_done = (c == TIMEOUT);
    end
    tpu_done = 1'b0;
    vectors++;
    if (at != TIMEOUT + 1 || rq_n != 0 || int'(cmp_cycles) != TIMEOUT || cmp_timeout !== 1'b0 || int'(cmp_id) != 9) begin
      errors++; $display("FAIL race_record: at %0d rst_req %0d id %0d cyc %0d to %0b expected %0d 0 9 %0d 0",
                         at, rq_n, cmp_id, cmp_cycles, cmp_timeout, TIMEOUT + 1, TIMEOUT);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int at = -1;
    cmp_ready = 1'b0;
    job_valid = 1'b1; job_id = 4'd6; job_set = 2'd0;
    tick();
    job_id = 4'd7; job_set = 2'd1;
    tick();
    job_valid = 1'b0;
    vectors++;
    if (tpu_start !== 1'b1 || int'(q_level) != 1) begin
      errors++; $display("FAIL bp_first_start: start %0b level %0d expected 1 1", tpu_start, q_level);
    end
    for (int c = 1; c <= 40 && at < 0; c++) begin
      tick();
      if (cmp_valid) at = c;
      tpu_done = (c == 5);
    end
    tpu_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (cmp_valid !== 1'b1 || int'(cmp_id) != 6 || int'(cmp_cycles) != 5 || cmp_timeout !== 1'b0 || tpu_start !== 1'b0) begin
        errors++; $display("FAIL bp_hold %0d: valid %0b id %0d cyc %0d to %0b start %0b expected 1 6 5 0 0",
                           i, cmp_valid, cmp_id, cmp_cycles, cmp_timeout, tpu_start);
      end
      tick();
    end
    cmp_ready = 1'b1;
    tick();
    vectors++;
    if (cmp_valid !== 1'b0 || tpu_start !== 1'b0) begin
      errors++; $display("FAIL bp_handshake: valid %0b start %0b expected 0 0", cmp_valid, tpu_start);
    end
    tick();
    vectors++;
    if (tpu_start !== 1'b1 || tpu_job_set !== 2'd1) begin
      errors++; $display("FAIL bp_second_start: start %0b set %0d expected 1 1", tpu_start, tpu_job_set);
    end
    at = -1;
    for (int c = 1; c <= 40 && at < 0; c++) begin
      tick();
      if (cmp_valid) at = c;
      tpu_done = (c == 2);
    end
    tpu_done = 1'b0;
    vectors++;
    if (at != 3 || int'(cmp_id) != 7 || int'(cmp_cycles) != 2) begin
      errors++; $display("FAIL bp_second_record: at %0d id %0d cyc %0d expected 3 7 2", at, cmp_id, cmp_cycles);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int all_out, stray = 0;
    cmp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      job_valid = 1'b1; job_id = ID_W'(10 + i); job_set = 2'(i);
      tick();
    end
    job_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (int'(q_level) != 2 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset: level %0d busy %0b expected 2 1", q_level, busy);
    end
    #2 srst = 1'b1;
    #1;
    all_out = int'({tpu_start, tpu_rst_req, cmp_valid, cmp_id, cmp_cycles,
                    cmp_timeout, tpu_job_set, busy, q_level, job_ready});
    vectors++;
    if (all_out !== 0) begin errors++; $display("FAIL mid_async_clear: got %0h expected 0", all_out); end
    @(posedge clk);
    #3 srst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (tpu_start || cmp_valid) stray++;
    end
    vectors++;
    if (stray != 0 || job_ready !== 1'b1 || busy !== 1'b0 || int'(q_level) != 0) begin
      errors++; $display("FAIL mid_after_release: stray %0d ready %0b busy %0b level %0d expected 0 1 0 0",
                         stray, job_ready, busy, q_level);
    end
  endtask

  // Model: FIFO order of accepted descriptors, occupancy from pushes minus
  // starts, and each record derived from the chosen tpu_top latency.
  task automatic test_random();
    localparam int N = 40;
    logic [ID_W+1:0] dq[$];
    int cq_id[$], cq_cyc[$], cq_to[$];
    int pushed = 0, started = 0, done_n = 0, lvl = 0, n_to = 0, rq_seen = 0;
    int tcyc = 0, dly = 0;
    bit armed = 0, push_pend = 0;
    logic [ID_W+1:0] d;
    tpu_done = 1'b0; cmp_ready = 1'b0; job_valid = 1'b0;
    for (int c = 0; c < 20000 && done_n < N; c++) begin
      tick();
      if (push_pend) lvl++;
      if (tpu_start) begin
        started++;
        lvl--;
        armed = 1; tcyc = 0; dly = $urandom_range(26, 1);
        vectors++;
        if (dq.size() == 0) begin
          errors++; $display("FAIL rnd_start_no_job: start %0d with empty model queue", started);
        end else begin
          d = dq.pop_front();
          if (tpu_job_set !== d[1:0]) begin
            errors++; $display("FAIL rnd_job_set: got %0d expected %0d", tpu_job_set, d[1:0]);
          end
          cq_id.push_back(int'(d[ID_W+1:2]));
          cq_cyc.push_back(dly <= TIMEOUT ? dly : TIMEOUT);
          cq_to.push_back(dly > TIMEOUT ? 1 : 0);
          if (dly > TIMEOUT) n_to++;
        end
      end else if (armed) tcyc++;
      vectors++;
      if (int'(q_level) != lvl || job_ready !== (lvl < QDEPTH)) begin
        errors++; $display("FAIL rnd_level: level %0d ready %0b expected %0d %0b", q_level, job_ready, lvl, lvl < QDEPTH);
      end
      if (tpu_rst_req) rq_seen++;
      tpu_done  = armed && (tcyc == dly);
      cmp_ready = ($urandom_range(3, 0) != 0);
      if (cmp_valid && cmp_ready) begin
        vectors++;
        if (cq_id.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected_record: id %0d", cmp_id);
        end else begin
          if (int'(cmp_id) != cq_id[0] || int'(cmp_cycles) != cq_cyc[0] || int'(cmp_timeout) != cq_to[0]) begin
            errors++; $display("FAIL rnd_record %0d: id %0d cyc %0d to %0b expected %0d %0d %0d",
                               done_n, cmp_id, cmp_cycles, cmp_timeout, cq_id[0], cq_cyc[0], cq_to[0]);
          end
          void'(cq_id.pop_front()); void'(cq_cyc.pop_front()); void'(cq_to.pop_front());
        end
        done_n++;
      end
      job_valid = (pushed < N) && ($urandom_range(1, 0) == 1);
      job_id    = ID_W'($urandom_range(15, 0));
      job_set   = 2'($urandom_range(3, 0));
      push_pend = job_valid && job_ready;
      if (push_pend) begin
        dq.push_back({job_id, job_set});
        pushed++;
      end
    end
    tick();
    job_valid = 1'b0; tpu_done = 1'b0;
    vectors++;
    if (done_n != N || started != N || rq_seen != RST_CYCLES * n_to) begin
      errors++; $display("FAIL rnd_totals: records %0d starts %0d rst_req_cycles %0d expected %0d %0d %0d",
                         done_n, started, rq_seen, N, N, RST_CYCLES * n_to);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_race();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
